// File: rtl/splitter.sv
// Eager fork: each accepted S value is split into a floor half on A and a
// ceiling half on B, each held in its own output slot until its consumer takes it.
module splitter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 S_valid,
  output logic                 S_ready,
  input  logic [WIDTH:0]       S_data,
  output logic                 A_valid,
  input  logic                 A_ready,
  output logic [WIDTH-1:0]     A_data,
  output logic                 B_valid,
  input  logic                 B_ready,
  output logic [WIDTH-1:0]     B_data,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 ovf
);

  localparam logic [WIDTH:0] S_MAX = '1;

  logic                 a_valid_q, a_valid_d;
  logic                 b_valid_q, b_valid_d;
  logic [WIDTH-1:0]     a_data_q,  a_data_d;
  logic [WIDTH-1:0]     b_data_q,  b_data_d;
  logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic                 ovf_q,     ovf_d;

  logic                 s_xfer;
  logic                 s_oor;
  logic [WIDTH-1:0]     half_floor;
  logic [WIDTH-1:0]     half_ceil;

  // A slot may accept new data if it is empty or being drained this cycle.
  assign S_ready = (!a_valid_q || A_ready) && (!b_valid_q || B_ready);
  assign s_xfer  = S_valid && S_ready;

  // ceil(S/2) = floor(S/2) + lsb; cannot overflow WIDTH bits for in-range S.
  always_comb begin
    half_floor = S_data[WIDTH:1];
    half_ceil  = half_floor + WIDTH'(S_data[0]);
    s_oor      = (S_data == S_MAX);
  end

  always_comb begin
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (s_xfer) begin
      a_valid_d = 1'b1;
      b_valid_d = 1'b1;
      a_data_d  = s_oor ? '1 : half_floor;
      b_data_d  = s_oor ? '1 : half_ceil;
      cnt_d     = cnt_q + CNT_WIDTH'(1);
      ovf_d     = ovf_q || s_oor;
    end else begin
      if (A_ready) a_valid_d = 1'b0;
      if (B_ready) b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign A_valid    = a_valid_q;
  assign B_valid    = b_valid_q;
  assign A_data     = a_data_q;
  assign B_data     = b_data_q;
  assign xfer_count = cnt_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_splitter.sv
// Directed and model-checked stimulus for the splitter (WIDTH=8, CNT_WIDTH=16).
module tb_splitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        S_valid;
  logic        S_ready;
  logic [8:0]  S_data;
  logic        A_valid, A_ready;
  logic [7:0]  A_data;
  logic        B_valid, B_ready;
  logic [7:0]  B_data;
  logic [15:0] xfer_count;
  logic        ovf;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  splitter #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .S_valid(S_valid), .S_ready(S_ready), .S_data(S_data),
    .A_valid(A_valid), .A_ready(A_ready), .A_data(A_data),
    .B_valid(B_valid), .B_ready(B_ready), .B_data(B_data),
    .xfer_count(xfer_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_a(input int unsigned s);
    return (s == 511) ? 8'd255 : 8'(s / 2);
  endfunction

  function automatic logic [7:0] exp_b(input int unsigned s);
    return (s == 511) ? 8'd255 : 8'(s - s / 2);
  endfunction

  logic       ma_v, mb_v, m_rdy;
  logic [7:0] ma_d, mb_d;

  initial begin
    reset = 1'b1; S_valid = 1'b0; S_data = '0; A_ready = 1'b0; B_ready = 1'b0;
    step();
    check("rst_s_ready", 32'(S_ready), 1);
    step();
    check("rst_a_valid", 32'(A_valid), 0);
    check("rst_b_valid", 32'(B_valid), 0);
    check("rst_a_data",  32'(A_data), 0);
    check("rst_b_data",  32'(B_data), 0);
    check("rst_count",   32'(xfer_count), 0);
    check("rst_ovf",     32'(ovf), 0);
    reset = 1'b0;

    // Basic split of 7
    A_ready = 1'b1; B_ready = 1'b1; S_valid = 1'b1; S_data = 9'd7;
    step();
    S_valid = 1'b0;
    check("basic_a_valid", 32'(A_valid), 1);
    check("basic_b_valid", 32'(B_valid), 1);
    check("basic_a_data",  32'(A_data), 3);
    check("basic_b_data",  32'(B_data), 4);
    check("basic_count",   32'(xfer_count), 1);
    step();
    check("basic_a_drained", 32'(A_valid), 0);
    check("basic_b_drained", 32'(B_valid), 0);

    // Max legal and out-of-range values
    S_valid = 1'b1; S_data = 9'd510;
    step();
    check("max_a", 32'(A_data), 255);
    check("max_b", 32'(B_data), 255);
    check("max_ovf", 32'(ovf), 0);
    S_data = 9'd511;
    step();
    check("oor_a", 32'(A_data), 255);
    check("oor_b", 32'(B_data), 255);
    check("oor_ovf", 32'(ovf), 1);
    for (int i = 0; i < 10; i++) begin
      S_data = 9'(i * 3);
      step();
    end
    S_valid = 1'b0;
    check("ovf_sticky", 32'(ovf), 1);
    check("ovf_last_a", 32'(A_data), 13);
    check("ovf_last_b", 32'(B_data), 14);
    check("count_13", 32'(xfer_count), 13);
    step();

    // Independent drain: B stalls while A completes
    S_valid = 1'b1; S_data = 9'd100; A_ready = 1'b1; B_ready = 1'b0;
    step();
    S_valid = 1'b0;
    check("ind_a_data", 32'(A_data), 50);
    check("ind_b_data", 32'(B_data), 50);
    check("ind_s_ready_stall", 32'(S_ready), 0);
    step();
    check("ind_a_done", 32'(A_valid), 0);
    check("ind_b_held", 32'(B_valid), 1);
    check("ind_b_data_held", 32'(B_data), 50);
    check("ind_s_ready_still", 32'(S_ready), 0);
    B_ready = 1'b1;
    #1;
    check("ind_s_ready_same_cycle", 32'(S_ready), 1);
    step();
    check("ind_b_done", 32'(B_valid), 0);

    // Back-to-back 256 transfers, no bubbles
    S_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      S_data = 9'(i);
      #1;
      check("b2b_s_ready", 32'(S_ready), 1);
      step();
      check("b2b_sum", 32'(A_data) + 32'(B_data), 32'(i));
      check("b2b_valid", 32'(A_valid && B_valid), 1);
    end
    S_valid = 1'b0;
    check("b2b_count", 32'(xfer_count), 13 + 1 + 256);
    step();

    // Reset while both slots are stalled
    S_valid = 1'b1; S_data = 9'd20; A_ready = 1'b0; B_ready = 1'b0;
    step();
    S_valid = 1'b0;
    check("stall_s_ready", 32'(S_ready), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_a_valid", 32'(A_valid), 0);
    check("mrst_b_valid", 32'(B_valid), 0);
    check("mrst_count", 32'(xfer_count), 0);
    check("mrst_ovf", 32'(ovf), 0);
    check("mrst_s_ready", 32'(S_ready), 1);
    S_valid = 1'b1; S_data = 9'd1; A_ready = 1'b1; B_ready = 1'b1;
    step();
    check("mrst_first_a", 32'(A_data), 0);
    check("mrst_first_b", 32'(B_data), 1);
    check("mrst_first_count", 32'(xfer_count), 1);

    // Counter wrap: 65535 total, then one more
    for (int i = 1; i < 65535; i++) begin
      S_data = 9'(i & 9'h1ff);
      step();
    end
    check("wrap_pre", 32'(xfer_count), 65535);
    step();
    S_valid = 1'b0;
    check("wrap_zero", 32'(xfer_count), 0);

    // Randomized valid/ready stress against a slot-level model
    reset = 1'b1;
    step();
    reset = 1'b0;
    ma_v = 1'b0; mb_v = 1'b0; ma_d = '0; mb_d = '0;
    for (int i = 0; i < 500; i++) begin
      S_valid = 1'($urandom_range(0, 1));
      A_ready = ($urandom_range(0, 3) != 0);
      B_ready = ($urandom_range(0, 3) != 0);
      S_data  = ($urandom_range(0, 15) == 0) ? 9'd511 : 9'($urandom_range(0, 510));
      #1;
      m_rdy = (!ma_v || A_ready) && (!mb_v || B_ready);
      check("rnd_s_ready", 32'(S_ready), 32'(m_rdy));
      if (S_valid && m_rdy) begin
        ma_v = 1'b1; mb_v = 1'b1;
        ma_d = exp_a(int'(S_data)); mb_d = exp_b(int'(S_data));
      end else begin
        if (A_ready) ma_v = 1'b0;
        if (B_ready) mb_v = 1'b0;
      end
      step();
      check("rnd_a_valid", 32'(A_valid), 32'(ma_v));
      check("rnd_b_valid", 32'(B_valid), 32'(mb_v));
      check("rnd_a_data",  32'(A_data), 32'(ma_d));
      check("rnd_b_data",  32'(B_data), 32'(mb_d));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
